// File: rtl/paula_floppy_mfm_serializer_if.sv
// Bundle between the floppy FIFO read port, the write-DMA control and the
// MFM bit-cell serializer. The master side drives the controls and the FIFO
// head; the slave side (the serializer) returns the pop request and the bitstream.
interface paula_floppy_mfm_serializer_if #(
  parameter int unsigned LEN_W = 14
);
  logic             clk7_en;
  logic             enable;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [15:0]      fifo_in;
  logic             fifo_empty;
  logic             fifo_rd;
  logic             bit_out;
  logic             bit_strobe;
  logic             busy;
  logic             done;
  logic             underrun;
  logic [LEN_W-1:0] words_left;

  modport master (
    output clk7_en, enable, start, len, fifo_in, fifo_empty,
    input  fifo_rd, bit_out, bit_strobe, busy, done, underrun, words_left
  );

  modport slave (
    input  clk7_en, enable, start, len, fifo_in, fifo_empty,
    output fifo_rd, bit_out, bit_strobe, busy, done, underrun, words_left
  );
endinterface

// File: rtl/paula_floppy_mfm_serializer.sv
// Disk-write MFM serializer: pops 16-bit words from the floppy FIFO and shifts
// them out MSB-first as bit cells of CELL_DIV enabled cycles each. One word is
// prefetched into a hold register so consecutive words form a gapless stream.
module paula_floppy_mfm_serializer #(
  parameter int unsigned CELL_DIV = 14,
  parameter int unsigned LEN_W    = 14
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  paula_floppy_mfm_serializer_if.slave bus_io
);

  localparam int unsigned      CellW    = (CELL_DIV > 1) ? $clog2(CELL_DIV) : 1;
  localparam logic [CellW-1:0] CellLast = CellW'(CELL_DIV - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StPrime = 3'd1;
  localparam logic [2:0] StShift = 3'd2;
  localparam logic [2:0] StStall = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [15:0]      shreg_q, shreg_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [CellW-1:0] cellcnt_q, cellcnt_d;
  logic [15:0]      hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic [LEN_W-1:0] fetch_left_q, fetch_left_d;
  logic [LEN_W-1:0] words_left_q, words_left_d;
  logic             guard_q, guard_d;
  logic             bit_q, bit_d;
  logic             strobe_q, strobe_d;
  logic             underrun_q, underrun_d;

  logic active;
  logic fetch;
  logic load;

  assign active = (state_q == StPrime) || (state_q == StShift) || (state_q == StStall);

  // Guard blocks a second pop right after the first: the empty flag and the
  // registered head word both trail a pop by one enabled cycle.
  assign fetch = active && bus_io.enable && !hold_valid_q && (fetch_left_q != '0) &&
                 !bus_io.fifo_empty && !guard_q;

  // Next-state logic: prefetch, FSM sequencing, cell timing and abort.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    cellcnt_d    = cellcnt_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    fetch_left_d = fetch_left_q;
    words_left_d = words_left_q;
    guard_d      = 1'b0;
    bit_d        = bit_q;
    strobe_d     = 1'b0;
    underrun_d   = underrun_q;
    load         = 1'b0;

    if (fetch) begin
      hold_d       = bus_io.fifo_in;
      hold_valid_d = 1'b1;
      fetch_left_d = fetch_left_q - LEN_W'(1);
      guard_d      = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (bus_io.start && bus_io.enable) begin
          if (bus_io.len != '0) begin
            fetch_left_d = bus_io.len;
            words_left_d = bus_io.len;
            underrun_d   = 1'b0;
            state_d      = StPrime;
          end else begin
            state_d = StDone;
          end
        end
      end
      StPrime, StStall: begin
        // Stall restarts cell timing from scratch, exactly like the first word.
        if (hold_valid_q) begin
          load = 1'b1;
        end
      end
      StShift: begin
        cellcnt_d = cellcnt_q + CellW'(1);
        if (cellcnt_q == CellLast) begin
          cellcnt_d = '0;
          if (bitcnt_q != 4'd0) begin
            shreg_d  = {shreg_q[14:0], 1'b0};
            bit_d    = shreg_q[14];
            strobe_d = 1'b1;
            bitcnt_d = bitcnt_q - 4'd1;
          end else begin
            words_left_d = words_left_q - LEN_W'(1);
            if (words_left_q == LEN_W'(1)) begin
              bit_d   = 1'b0;
              state_d = StDone;
            end else if (hold_valid_q) begin
              load = 1'b1;
            end else begin
              underrun_d = 1'b1;
              bit_d      = 1'b0;
              state_d    = StStall;
            end
          end
        end
      end
      StDone: begin
        bit_d   = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (load) begin
      shreg_d      = hold_q;
      hold_valid_d = 1'b0;
      bitcnt_d     = 4'd15;
      cellcnt_d    = '0;
      bit_d        = hold_q[15];
      strobe_d     = 1'b1;
      state_d      = StShift;
    end

    // Abort wins over everything; the sticky underrun survives it.
    if ((state_q != StIdle) && !bus_io.enable) begin
      state_d      = StIdle;
      shreg_d      = '0;
      bitcnt_d     = '0;
      cellcnt_d    = '0;
      hold_d       = '0;
      hold_valid_d = 1'b0;
      fetch_left_d = '0;
      words_left_d = '0;
      guard_d      = 1'b0;
      bit_d        = 1'b0;
      strobe_d     = 1'b0;
    end
  end

  // State registers: async reset, advance only on clk7_en.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      cellcnt_q    <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      fetch_left_q <= '0;
      words_left_q <= '0;
      guard_q      <= 1'b0;
      bit_q        <= 1'b0;
      strobe_q     <= 1'b0;
      underrun_q   <= 1'b0;
    end else if (bus_io.clk7_en) begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      cellcnt_q    <= cellcnt_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      fetch_left_q <= fetch_left_d;
      words_left_q <= words_left_d;
      guard_q      <= guard_d;
      bit_q        <= bit_d;
      strobe_q     <= strobe_d;
      underrun_q   <= underrun_d;
    end
  end

  // Pulses are qualified by clk7_en so each lasts exactly one enabled cycle.
  assign bus_io.fifo_rd    = bus_io.clk7_en && fetch;
  assign bus_io.bit_strobe = bus_io.clk7_en && strobe_q;
  assign bus_io.done       = bus_io.clk7_en && (state_q == StDone);
  assign bus_io.bit_out    = bit_q;
  assign bus_io.busy       = active;
  assign bus_io.underrun   = underrun_q;
  assign bus_io.words_left = words_left_q;

endmodule

// File: tb/tb_paula_floppy_mfm_serializer.sv
// Bench for the MFM serializer: a FIFO model with registered head and lagging
// empty flag feeds the DUT; stimulus pushes the expected bitstream into a
// scoreboard and a monitor pops and compares on every strobe and done pulse.
module tb_paula_floppy_mfm_serializer;
  localparam int unsigned CELL_DIV = 14;
  localparam int unsigned LEN_W    = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  paula_floppy_mfm_serializer_if #(.LEN_W(LEN_W)) bus ();

  paula_floppy_mfm_serializer #(.CELL_DIV(CELL_DIV), .LEN_W(LEN_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard and monitor bookkeeping
  bit exp_bits[$];
  int exp_done[$];
  int en_cyc      = 0;
  int rd_count    = 0;
  int strobe_cnt  = 0;
  int done_count  = 0;
  int last_rd     = -100;
  int last_strobe = -1;
  int bit_idx     = 0;
  int cur_len     = 0;
  bit nostall     = 1'b1;
  int en_mode     = 0;
  bit en_low      = 1'b0;

  // FIFO model
  logic [15:0] fifo_q[$];
  logic [15:0] fifo_head    = 16'h0;
  logic        fifo_empty_r = 1'b1;
  assign bus.fifo_in    = fifo_head;
  assign bus.fifo_empty = fifo_empty_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Clock-enable generator
  initial begin
    bus.clk7_en = 1'b1;
    forever begin
      @(negedge clk);
      if (en_low) bus.clk7_en = 1'b0;
      else if (en_mode == 1) bus.clk7_en = ($urandom_range(0, 3) != 0);
      else bus.clk7_en = 1'b1;
    end
  end

  // FIFO: head word registered, empty flag trails the queue by one enabled cycle
  always @(posedge clk) begin
    bit was_empty;
    if (bus.clk7_en) begin
      was_empty = (fifo_q.size() == 0);
      if (bus.fifo_rd && !was_empty) void'(fifo_q.pop_front());
      fifo_empty_r <= was_empty;
      fifo_head    <= (fifo_q.size() != 0) ? fifo_q[0] : 16'h0;
    end
  end

  // Monitor: sampled mid-cycle, after inputs for the coming edge have settled
  always @(negedge clk) begin
    bit b;
    int l;
    #1;
    if (!rst) begin
      if (bus.clk7_en) begin
        en_cyc++;
        if (bus.fifo_rd) begin
          check("rd_not_back_to_back", 32'(en_cyc - last_rd >= 2), 32'd1);
          last_rd = en_cyc;
          rd_count++;
        end
        if (bus.bit_strobe) begin
          check("strobe_expected", 32'(exp_bits.size() != 0), 32'd1);
          if (exp_bits.size() != 0) begin
            b = exp_bits.pop_front();
            check("bit_value", 32'(bus.bit_out), 32'(b));
          end
          check("words_left", 32'(bus.words_left), 32'(cur_len - bit_idx / 16));
          if (nostall && last_strobe >= 0)
            check("strobe_spacing", 32'(en_cyc - last_strobe), CELL_DIV);
          last_strobe = en_cyc;
          bit_idx++;
          strobe_cnt++;
        end
        if (bus.done) begin
          check("done_expected", 32'(exp_done.size() != 0), 32'd1);
          if (exp_done.size() != 0) begin
            l = exp_done.pop_front();
            if (l != 0) check("done_gap", 32'(en_cyc - last_strobe), CELL_DIV);
            check("done_words_left", 32'(bus.words_left), 32'd0);
            check("done_all_bits", 32'(exp_bits.size()), 32'd0);
          end
          done_count++;
        end
      end else begin
        check("pulse_gating", 32'({bus.bit_strobe, bus.done, bus.fifo_rd}), 32'd0);
      end
    end
  end

  task automatic push_word(input logic [15:0] w);
    fifo_q.push_back(w);
    for (int i = 15; i >= 0; i--) exp_bits.push_back(w[i]);
  endtask

  task automatic flush();
    exp_bits.delete();
    exp_done.delete();
    fifo_q.delete();
  endtask

  task automatic pulse_start(input int l);
    @(negedge clk);
    bus.len   = LEN_W'(l);
    bus.start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (bus.clk7_en) break;
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic begin_xfer(input int l, input bit ns);
    cur_len     = l;
    bit_idx     = 0;
    last_strobe = -1;
    nostall     = ns;
    exp_done.push_back(l);
    pulse_start(l);
  endtask

  task automatic wait_done(input int limit);
    int d0;
    d0 = done_count;
    for (int i = 0; i < limit && done_count == d0; i++) @(negedge clk);
    check("done_seen", 32'(done_count - d0), 32'd1);
  endtask

  task automatic wait_bits(input int n);
    for (int i = 0; i < 20000 && bit_idx < n; i++) @(negedge clk);
    check("bits_reached", 32'(bit_idx >= n), 32'd1);
  endtask

  task automatic wait_en(input int n);
    int e0;
    e0 = en_cyc;
    for (int i = 0; i < 100 * n && (en_cyc - e0) < n; i++) @(negedge clk);
  endtask

  // Watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, s0, d0, l, npre;
    bus.enable = 1'b1;
    bus.start  = 1'b0;
    bus.len    = '0;
    #2;
    check("reset_outputs", 32'({bus.bit_out, bus.bit_strobe, bus.busy, bus.done, bus.underrun,
                               bus.fifo_rd, bus.words_left}), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    wait_en(3);

    // 1: two preloaded sync/pattern words; a start while busy must be ignored
    push_word(16'h4489);
    push_word(16'hAAAA);
    wait_en(3);
    r0 = rd_count;
    begin_xfer(2, 1'b1);
    wait_bits(5);
    pulse_start(9);
    wait_done(2000);
    check("s1_reads", 32'(rd_count - r0), 32'd2);
    check("s1_bits", 32'(bit_idx), 32'd32);
    check("s1_underrun", 32'(bus.underrun), 32'd0);
    check("s1_busy_after", 32'(bus.busy), 32'd0);

    // 2: FIFO empty at start; word arrives late, no underrun while priming
    wait_en(5);
    r0 = rd_count;
    begin_xfer(1, 1'b1);
    s0 = strobe_cnt;
    wait_en(50);
    check("s2_no_strobes", 32'(strobe_cnt - s0), 32'd0);
    check("s2_underrun", 32'(bus.underrun), 32'd0);
    check("s2_busy", 32'(bus.busy), 32'd1);
    push_word(16'h8001);
    wait_done(2000);
    check("s2_bits", 32'(bit_idx), 32'd16);
    check("s2_reads", 32'(rd_count - r0), 32'd1);

    // 3: third word missing -> stall with underrun, resume when it arrives
    wait_en(5);
    r0 = rd_count;
    push_word(16'($urandom_range(0, 16'hFFFF)));
    push_word(16'($urandom_range(0, 16'hFFFF)));
    begin_xfer(3, 1'b0);
    for (int i = 0; i < 5000 && !bus.underrun; i++) @(negedge clk);
    check("s3_underrun_set", 32'(bus.underrun), 32'd1);
    wait_en(2);
    check("s3_stall_bits", 32'(bit_idx), 32'd32);
    check("s3_stall_bit_out", 32'(bus.bit_out), 32'd0);
    check("s3_stall_busy", 32'(bus.busy), 32'd1);
    s0 = strobe_cnt;
    wait_en(30);
    check("s3_stall_quiet", 32'(strobe_cnt - s0), 32'd0);
    push_word(16'h0F0F);
    wait_done(2000);
    check("s3_bits", 32'(bit_idx), 32'd48);
    check("s3_underrun_sticky", 32'(bus.underrun), 32'd1);
    check("s3_reads", 32'(rd_count - r0), 32'd3);

    // 4: abort mid second word with a random clock enable
    wait_en(5);
    en_mode = 1;
    for (int i = 0; i < 4; i++) push_word(16'($urandom_range(0, 16'hFFFF)));
    begin_xfer(4, 1'b1);
    check("s4_underrun_cleared", 32'(bus.underrun), 32'd0);
    wait_bits(16 + int'($urandom_range(1, 10)));
    @(negedge clk);
    bus.enable = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (bus.clk7_en) break;
    end
    flush();
    r0 = rd_count;
    s0 = strobe_cnt;
    d0 = done_count;
    @(negedge clk);
    #2;
    check("s4_busy_dropped", 32'(bus.busy), 32'd0);
    wait_en(60);
    check("s4_no_reads", 32'(rd_count - r0), 32'd0);
    check("s4_no_strobes", 32'(strobe_cnt - s0), 32'd0);
    check("s4_no_done", 32'(done_count - d0), 32'd0);
    bus.enable = 1'b1;
    en_mode = 0;
    wait_en(5);

    // 5: async reset between edges mid-transfer, then a zero-length start
    push_word(16'h1234);
    push_word(16'h5678);
    wait_en(3);
    begin_xfer(2, 1'b1);
    wait_bits(20);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("s5_reset_outputs", 32'({bus.bit_out, bus.bit_strobe, bus.busy, bus.done,
                                  bus.underrun, bus.fifo_rd, bus.words_left}), 32'd0);
    flush();
    @(negedge clk);
    #2 rst = 1'b0;
    wait_en(4);
    r0 = rd_count;
    begin_xfer(0, 1'b1);
    wait_done(200);
    check("s5_len0_no_reads", 32'(rd_count - r0), 32'd0);

    // 6: clock enable held low mid-cell; spacing in enabled cycles unchanged
    wait_en(5);
    r0 = rd_count;
    push_word(16'hC3A5);
    push_word(16'h5A3C);
    wait_en(3);
    begin_xfer(2, 1'b1);
    wait_bits(7);
    wait_en(5);
    @(posedge clk);
    en_low = 1'b1;
    s0 = strobe_cnt;
    d0 = rd_count;
    repeat (20) @(negedge clk);
    @(posedge clk);
    en_low = 1'b0;
    check("s6_frozen_strobes", 32'(strobe_cnt - s0), 32'd0);
    check("s6_frozen_reads", 32'(rd_count - d0), 32'd0);
    wait_done(2000);
    check("s6_reads", 32'(rd_count - r0), 32'd2);

    // 7: randomized lengths, words and arrival times under a random enable
    en_mode = 1;
    for (int t = 0; t < 6; t++) begin
      wait_en(5);
      l    = int'($urandom_range(1, 4));
      npre = int'($urandom_range(0, 1)) == 1 ? l : int'($urandom_range(0, l));
      r0   = rd_count;
      for (int i = 0; i < npre; i++) push_word(16'($urandom_range(0, 16'hFFFF)));
      wait_en(3);
      begin_xfer(l, npre == l);
      for (int i = npre; i < l; i++) begin
        repeat ($urandom_range(10, 300)) @(negedge clk);
        push_word(16'($urandom_range(0, 16'hFFFF)));
      end
      wait_done(8000);
      check("s7_reads", 32'(rd_count - r0), 32'(l));
      check("s7_bits", 32'(bit_idx), 32'(16 * l));
      if (npre == l) check("s7_no_underrun", 32'(bus.underrun), 32'd0);
    end
    en_mode = 0;
    wait_en(5);
    check("end_scoreboard_empty", 32'(exp_bits.size() + exp_done.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/paula_floppy_mfm_serializer.md
Name: paula_floppy_mfm_serializer

Overview:
- Disk-write side of the floppy path. Drains 16-bit MFM words from the floppy FIFO, which has a registered output and a one-cycle-delayed empty flag.
- Shifts the words out MSB-first as a bit-cell stream at a programmable cell rate.
- Sits between the floppy FIFO read port and the drive write-data pin / host write-capture logic.
- Holds one prefetched word so the bitstream is continuous across word boundaries.

Parameters:
- CELL_DIV, 14, clk7_en-qualified cycles per bit cell (14 gives 2 us cells at 7 MHz).
- LEN_W, 14, width of the word-length field.

Ports:
- clk  in  1  bus clock
- reset  in  1  asynchronous, active-high reset
- clk7_en  in  1  clock enable; all sequential logic advances only when clk7_en=1
- enable  in  1  write DMA enabled; low aborts the transfer
- start  in  1  single-enabled-cycle pulse that begins a transfer
- len  in  LEN_W  number of words to send; sampled on start
- fifo_in  in  16  FIFO registered output (current head word)
- fifo_empty  in  1  FIFO empty flag (lags by one enabled cycle)
- fifo_rd  out  1  FIFO read/pop request
- bit_out  out  1  current cell data bit
- bit_strobe  out  1  pulse marking the start of each cell
- busy  out  1  transfer in progress
- done  out  1  pulse after the last bit cell completes
- underrun  out  1  sticky flag: a cell boundary found no data available
- words_left  out  LEN_W  words not yet fully shifted out

Behaviour:
- Reset (asynchronous, immediate): all outputs 0; state IDLE; shift register, hold register and counters cleared.
- Registers: shreg[15:0], bitcnt[3:0], cellcnt (0..CELL_DIV-1), hold[15:0], hold_valid, fetch_left, words_left, guard (1 bit).
- Fetch rule (active in PRIME, SHIFT and STALL):
  - Condition: hold_valid=0, fetch_left!=0, fifo_empty=0, guard=0.
  - Action: fifo_rd=1 for one enabled cycle; hold<=fifo_in sampled in that same cycle; hold_valid<=1; fetch_left-=1; guard<=1.
  - guard clears on the next enabled cycle, so there are never back-to-back reads. This covers the stale empty flag and the RAM delay.
- States:
  - IDLE: busy=0. start=1 with enable=1 and len!=0 loads fetch_left=words_left=len, clears underrun, goes to PRIME. start with len=0 gives a done pulse and no reads.
  - PRIME: wait until hold_valid=1, then shreg<=hold, hold_valid<=0, bitcnt=15, cellcnt=0, bit_out=hold[15], bit_strobe=1, go to SHIFT. No timeout; underrun is not flagged here.
  - SHIFT: cellcnt increments each enabled cycle. When cellcnt=CELL_DIV-1:
    - cellcnt<=0.
    - If bitcnt!=0: shreg shifts left, bit_out=next MSB, bit_strobe=1, bitcnt-=1.
    - If bitcnt=0: words_left-=1. If words_left becomes 0, go to DONE. Otherwise, if hold_valid=1, reload shreg from hold, bitcnt=15, emit its MSB with a strobe. If hold_valid=0, set underrun=1, bit_out=0, go to STALL.
  - STALL: no strobes; bit_out=0. When hold_valid=1, behave as PRIME (restart the cell timing).
  - DONE: done=1 and busy=0 for one enabled cycle, bit_out=0, then IDLE.
- busy=1 in PRIME, SHIFT and STALL.
- Abort: enable=0 in any non-IDLE state goes to IDLE on the next enabled cycle.
  - Discards hold, clears counters.
  - No done pulse; underrun is retained.
  - No fifo_rd is asserted in that cycle.
- Pulse gating: bit_strobe, done and fifo_rd are asserted only in cycles with clk7_en=1 and are 0 otherwise.
- Width rule: words_left and fetch_left are LEN_W wide, unsigned. len=max is legal; there is no wrap.
- start while busy is ignored.

Test Plan:
- CELL_DIV=14, FIFO preloaded 0x4489 then 0xAAAA, start with len=2 -> exactly 2 fifo_rd pulses, non-adjacent; 32 strobes spaced 14 enabled cycles apart; bits 0100010010001001 then 1010101010101010; done one pulse 14 enabled cycles after the last strobe; underrun=0; words_left counts 2,1,0.
- FIFO empty at start with len=1; push 0x8001 after 50 enabled cycles -> no strobes and underrun=0 before the push; then 16 strobes emitting 1000000000000001; done.
- len=3 with only 2 words available, third word pushed late -> STALL after bit 32, underrun=1, bit_out=0; output resumes with a fresh cell once the word arrives; underrun stays 1 until the next start.
- enable dropped mid-word during the second word of len=4 -> busy=0 the next enabled cycle; no further fifo_rd or strobes; done never pulses.
- Async reset asserted between clk edges mid-transfer -> all outputs 0 immediately; a subsequent start with len=0 produces a done pulse and no fifo_rd.
- clk7_en held low for 20 cycles mid-cell -> cellcnt frozen; strobe spacing measured in enabled cycles still 14; no extra reads.
